zstall_arb: RTL
===============

ZSTALL_ARB -- requirements
Module: zstall_arb

Interface
REQ-001 SHALL have parameter MAX_STALL, default 8'd200: maximum fclk cycles a single stall may last before forced release.
REQ-002 SHALL have parameter TURBO_RST, default 2'b00: turbo value after reset (3.5 MHz).
REQ-003 SHALL have port fclk, input, 1: sole clock, 28 MHz; all logic on posedge; one clock, reset asynchronous active-low.
REQ-004 SHALL have port rst_n, input, 1: asynchronous active-low reset.
REQ-005 SHALL have port zpos, input, 1: one-fclk strobe, Z80 clock rising edge, from the Z80 clock generator.
REQ-006 SHALL have port zneg, input, 1: one-fclk strobe, Z80 clock falling edge.
REQ-007 SHALL have port turbo_cfg, input, 2: requested turbo from config register (00 3.5, 01 7, 1x 14 MHz).
REQ-008 SHALL have port ext_wait, input, 1: level stall request, priority 0 (highest).
REQ-009 SHALL have port dma_req, input, 1: level request for Z80-bus ownership, priority 1.
REQ-010 SHALL have port dram_busy, input, 1: level stall request for a DRAM slot collision, priority 2.
REQ-011 SHALL have port zclk_stall, output, 1: stall to the Z80 clock generator.
REQ-012 SHALL have port turbo, output, 2: turbo to the Z80 clock generator.
REQ-013 SHALL have port dma_gnt, output, 1: DMA bus grant.
REQ-014 SHALL have port stall_src, output, 2: owner of the current stall (0 none, 1 ext, 2 dma, 3 dram).
REQ-015 SHALL have port timeout_err, output, 1: sticky, set on forced release.

Function
REQ-016 SHALL implement FSM states RUN, ARM, STALL, GRANT, RELEASE.
REQ-017 RUN: on a zneg strobe with any request active, SHALL latch the highest-priority requester into stall_src and go to ARM; requests outside a zneg strobe SHALL wait for the next zneg.
REQ-018 ARM: SHALL assert zclk_stall, clear the stall counter, and go next cycle to STALL, or to GRANT when the owner is dma; Z80 clock is thereby frozen high.
REQ-019 STALL: SHALL hold zclk_stall until the owner's request drops, then go to RELEASE; the owner SHALL NOT change mid-stall, even when a higher-priority request arrives.
REQ-020 GRANT: SHALL assert dma_gnt together with zclk_stall; on dma_req low SHALL deassert dma_gnt the same cycle and go to RELEASE.
REQ-021 RELEASE: SHALL deassert zclk_stall, set stall_src to 0, and return to RUN after exactly one cycle; a new stall SHALL be taken no earlier than the next zneg.
REQ-022 Stall counter, 8 bits, SHALL increment each cycle in STALL/GRANT, saturating; on reaching MAX_STALL SHALL force RELEASE, drop dma_gnt, and set timeout_err.
REQ-023 After a forced release, the same requester SHALL be ignored until its request has been seen low for at least one cycle.
REQ-024 turbo SHALL update from turbo_cfg only in RUN, on a zpos strobe, and only when no stall is pending; latency turbo_cfg to turbo is at most one Z80 clock period.
REQ-025 zpos and zneg in the same cycle SHALL be treated as zneg only.
REQ-026 zclk_stall, dma_gnt and stall_src SHALL be registered outputs, with no combinational path from inputs.

Reset
REQ-027 On rst_n low SHALL force state RUN, zclk_stall 0, dma_gnt 0, stall_src 0, timeout_err 0, counter 0, turbo TURBO_RST, asynchronously.
REQ-028 Reset asserted mid-stall SHALL release the stall and the grant immediately; after rst_n rises the first stall SHALL wait for a zneg.
REQ-029 Only reset SHALL clear timeout_err.

Structure
REQ-030 State encoding, stall_src codes and turbo codes SHALL live in the shared include alongside the tune defines.
REQ-031 The design SHALL be a single module; the priority encoder and the counter SHALL be inline, with no sub-module.

Verification
REQ-032 Stall: dram_busy high for 10 cycles before a zneg -> zclk_stall rises 2 cycles after zneg, stall_src=3, and falls 1 cycle after dram_busy drops.
REQ-033 DMA: dma_req held -> dma_gnt=1 two cycles after zneg; dma_req low -> dma_gnt 0 the same cycle, zclk_stall 0 the next cycle.
REQ-034 Priority: ext_wait and dram_busy both high at zneg -> stall_src=1; dram stall follows at the next zneg after ext_wait drops.
REQ-035 Timeout: MAX_STALL=8, dma_req stuck high -> forced release after 8 stall cycles, timeout_err=1, no new grant until dma_req has been low.
REQ-036 Turbo: turbo_cfg 00->01 during a stall -> turbo stays 00 until the first zpos in RUN, then becomes 01.
REQ-037 Reset mid-GRANT: rst_n pulse -> dma_gnt=0, zclk_stall=0, turbo=TURBO_RST, all without an fclk edge.

Source files
------------

// File: rtl/zstall_arb_pkg.sv
// Shared encodings for the Z80 clock-stall arbiter: FSM states, stall owner codes, turbo codes.
package zstall_arb_pkg;

  typedef enum logic [2:0] {
    ST_RUN,
    ST_ARM,
    ST_STALL,
    ST_GRANT,
    ST_RELEASE
  } state_e;

  localparam logic [1:0] SRC_NONE = 2'd0;
  localparam logic [1:0] SRC_EXT  = 2'd1;
  localparam logic [1:0] SRC_DMA  = 2'd2;
  localparam logic [1:0] SRC_DRAM = 2'd3;

  localparam logic [1:0] TURBO_3M5 = 2'b00;
  localparam logic [1:0] TURBO_7M  = 2'b01;
  localparam logic [1:0] TURBO_14M = 2'b10;

  localparam logic [7:0] MAX_STALL_DEF = 8'd200;

endpackage

// File: rtl/zstall_arb.sv
// Arbitrates stall requests against the Z80 clock: freezes the clock high on a zneg,
// grants the bus to DMA, bounds every stall with a timeout and gates turbo changes.
module zstall_arb
  import zstall_arb_pkg::*;
#(
  parameter logic [7:0] MAX_STALL = MAX_STALL_DEF,
  parameter logic [1:0] TURBO_RST = TURBO_3M5
) (
  input  logic       fclk,
  input  logic       rst_n,
  input  logic       zpos,
  input  logic       zneg,
  input  logic [1:0] turbo_cfg,
  input  logic       ext_wait,
  input  logic       dma_req,
  input  logic       dram_busy,
  output logic       zclk_stall,
  output logic [1:0] turbo,
  output logic       dma_gnt,
  output logic [1:0] stall_src,
  output logic       timeout_err
);

  state_e     state_q, state_d;
  logic       zclk_stall_q, zclk_stall_d;
  logic       dma_gnt_q, dma_gnt_d;
  logic [1:0] stall_src_q, stall_src_d;
  logic       timeout_err_q, timeout_err_d;
  logic [1:0] turbo_q, turbo_d;
  logic [7:0] cnt_q, cnt_d;
  logic [2:0] blk_q, blk_d;

  logic [2:0] req_vec, elig, owner_mask;
  logic [1:0] pick;
  logic       zpos_only, owner_req, cnt_hit;

  // Bit order everywhere: [0] ext, [1] dma, [2] dram.
  assign req_vec   = {dram_busy, dma_req, ext_wait};
  assign elig      = req_vec & ~blk_q;
  assign zpos_only = zpos & ~zneg;
  assign cnt_hit   = ({1'b0, cnt_q} + 9'd1) >= {1'b0, MAX_STALL};
  assign owner_req = |(req_vec & owner_mask);

  always_comb begin
    pick = SRC_NONE;
    if (elig[0])      pick = SRC_EXT;
    else if (elig[1]) pick = SRC_DMA;
    else if (elig[2]) pick = SRC_DRAM;
  end

  always_comb begin
    owner_mask = 3'b000;
    case (stall_src_q)
      SRC_EXT:  owner_mask = 3'b001;
      SRC_DMA:  owner_mask = 3'b010;
      SRC_DRAM: owner_mask = 3'b100;
      default:  owner_mask = 3'b000;
    endcase
  end

  // NOTE: every next-state signal gets its hold value first, so no path leaves it unassigned (no latch).
  always_comb begin
    state_d       = state_q;
    zclk_stall_d  = zclk_stall_q;
    dma_gnt_d     = dma_gnt_q;
    stall_src_d   = stall_src_q;
    timeout_err_d = timeout_err_q;
    turbo_d       = turbo_q;
    cnt_d         = cnt_q;
    // A block on a timed-out requester lifts once its request is seen low.
    blk_d         = blk_q & req_vec;

    case (state_q)
      ST_RUN: begin
        if (zneg && (pick != SRC_NONE)) begin
          stall_src_d = pick;
          state_d     = ST_ARM;
        end else if (zpos_only && (pick == SRC_NONE)) begin
          turbo_d = turbo_cfg;
        end
      end
      ST_ARM: begin
        zclk_stall_d = 1'b1;
        cnt_d        = 8'd0;
        if (stall_src_q == SRC_DMA) begin
          dma_gnt_d = 1'b1;
          state_d   = ST_GRANT;
        end else begin
          state_d = ST_STALL;
        end
      end
      ST_STALL, ST_GRANT: begin
        cnt_d = (&cnt_q) ? cnt_q : cnt_q + 8'd1;
        if (!owner_req || cnt_hit) begin
          if (owner_req) begin
            timeout_err_d = 1'b1;
            blk_d         = blk_d | owner_mask;
          end
          state_d     = ST_RELEASE;
          stall_src_d = SRC_NONE;
          dma_gnt_d   = 1'b0;
          // After DMA the clock stays frozen one more cycle so the bus turns around first.
          if (state_q == ST_STALL) zclk_stall_d = 1'b0;
        end
      end
      ST_RELEASE: begin
        zclk_stall_d = 1'b0;
        state_d      = ST_RUN;
      end
      default: state_d = ST_RUN;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so all registers update from the same pre-edge values.
  always_ff @(posedge fclk or negedge rst_n) begin
    if (!rst_n) begin
      state_q       <= ST_RUN;
      zclk_stall_q  <= 1'b0;
      dma_gnt_q     <= 1'b0;
      stall_src_q   <= SRC_NONE;
      timeout_err_q <= 1'b0;
      turbo_q       <= TURBO_RST;
      cnt_q         <= 8'd0;
      blk_q         <= 3'b000;
    end else begin
      state_q       <= state_d;
      zclk_stall_q  <= zclk_stall_d;
      dma_gnt_q     <= dma_gnt_d;
      stall_src_q   <= stall_src_d;
      timeout_err_q <= timeout_err_d;
      turbo_q       <= turbo_d;
      cnt_q         <= cnt_d;
      blk_q         <= blk_d;
    end
  end

  assign zclk_stall  = zclk_stall_q;
  assign dma_gnt     = dma_gnt_q;
  assign stall_src   = stall_src_q;
  assign timeout_err = timeout_err_q;
  assign turbo       = turbo_q;

endmodule
